// File: rtl/rename_table_pkg.sv
// Shared constants, ROB state encoding and the renamed-slot record for the rename stage.
// Also hosts the source-operand select used by both rename slots.
package rename_table_pkg;

    localparam int LREG_NUM     = 32;
    localparam int LREG_WIDTH   = 5;
    localparam int PREG_WIDTH   = 6;
    localparam int FL_CNT_WIDTH = 6;
    localparam int RAT_RD_PORTS = 6;

    typedef enum logic [1:0] {
        ROB_STATE_IDLE     = 2'd0,
        ROB_STATE_ROLLBACK = 2'd1,
        ROB_STATE_WALK     = 2'd2
    } rob_state_e;

    typedef struct packed {
        logic                  valid;
        logic [PREG_WIDTH-1:0] prs1;
        logic [PREG_WIDTH-1:0] prs2;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] old_prd;
    } rn_slot_t;

    // x0 always reads as p0; an older slot in the same bundle overrides the table.
    function automatic logic [PREG_WIDTH-1:0] src_sel(
        input logic [LREG_WIDTH-1:0] lrs,
        input logic [PREG_WIDTH-1:0] rat_prd,
        input logic                  byp_en,
        input logic [LREG_WIDTH-1:0] byp_lrd,
        input logic [PREG_WIDTH-1:0] byp_prd
    );
        if (lrs == '0)
            return '0;
        else if (byp_en && (lrs == byp_lrd))
            return byp_prd;
        else
            return rat_prd;
    endfunction

endpackage

// File: rtl/rename_table_rat_array.sv
// Register alias table storage: async reads, two prioritized writes (port 1 wins),
// reset to the identity mapping and a single-cycle bulk load of the whole table.
module rat_array
    import rename_table_pkg::*;
#(
    parameter int NUM_ENTRIES = LREG_NUM,
    parameter int IDX_W       = LREG_WIDTH,
    parameter int DATA_W      = PREG_WIDTH,
    parameter int NUM_RD      = RAT_RD_PORTS
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  i_raddr     [NUM_RD],
    output logic [DATA_W-1:0] o_rdata     [NUM_RD],
    input  logic              i_wen0,
    input  logic [IDX_W-1:0]  i_waddr0,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic              i_wen1,
    input  logic [IDX_W-1:0]  i_waddr1,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_bulk_load,
    input  logic [DATA_W-1:0] i_bulk_data [NUM_ENTRIES],
    output logic [DATA_W-1:0] o_table     [NUM_ENTRIES]
);

    logic [DATA_W-1:0] r_map [NUM_ENTRIES];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                r_map[i] <= DATA_W'(i);
        end else if (i_bulk_load) begin
            r_map <= i_bulk_data;
        end else begin
            if (i_wen0)
                r_map[i_waddr0] <= i_wdata0;
            if (i_wen1)
                r_map[i_waddr1] <= i_wdata1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++)
            o_rdata[k] = r_map[i_raddr[k]];
    end

    assign o_table = r_map;

endmodule

// File: rtl/rename_table.sv
// 2-wide rename stage: speculative/architectural RATs, freelist allocation with
// compaction, intra-bundle bypass, registered output, and ROB rollback/walk recovery.
module rename_table
    import rename_table_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    instr0_valid,
    input  logic [LREG_WIDTH-1:0]   instr0_lrs1,
    input  logic [LREG_WIDTH-1:0]   instr0_lrs2,
    input  logic [LREG_WIDTH-1:0]   instr0_lrd,
    input  logic                    instr0_lrd_valid,
    input  logic                    instr1_valid,
    input  logic [LREG_WIDTH-1:0]   instr1_lrs1,
    input  logic [LREG_WIDTH-1:0]   instr1_lrs2,
    input  logic [LREG_WIDTH-1:0]   instr1_lrd,
    input  logic                    instr1_lrd_valid,

    output logic                    rn2fl_instr0_lrd_valid,
    output logic                    rn2fl_instr1_lrd_valid,
    input  logic [PREG_WIDTH-1:0]   fl2rn_instr0prd,
    input  logic [PREG_WIDTH-1:0]   fl2rn_instr1prd,
    input  logic [FL_CNT_WIDTH-1:0] fl2rn_free_count,

    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_instr0_valid,
    output logic [PREG_WIDTH-1:0]   out_instr0_prs1,
    output logic [PREG_WIDTH-1:0]   out_instr0_prs2,
    output logic [PREG_WIDTH-1:0]   out_instr0_prd,
    output logic [PREG_WIDTH-1:0]   out_instr0_old_prd,
    output logic                    out_instr1_valid,
    output logic [PREG_WIDTH-1:0]   out_instr1_prs1,
    output logic [PREG_WIDTH-1:0]   out_instr1_prs2,
    output logic [PREG_WIDTH-1:0]   out_instr1_prd,
    output logic [PREG_WIDTH-1:0]   out_instr1_old_prd,

    input  logic                    commit0_valid,
    input  logic                    commit0_need_to_wb,
    input  logic [LREG_WIDTH-1:0]   commit0_lrd,
    input  logic [PREG_WIDTH-1:0]   commit0_prd,
    input  logic                    commit1_valid,
    input  logic                    commit1_need_to_wb,
    input  logic [LREG_WIDTH-1:0]   commit1_lrd,
    input  logic [PREG_WIDTH-1:0]   commit1_prd,

    input  logic [1:0]              rob_state,
    input  logic                    walking_valid0,
    input  logic [LREG_WIDTH-1:0]   walking_lrd0,
    input  logic [PREG_WIDTH-1:0]   walking_prd0,
    input  logic                    walking_valid1,
    input  logic [LREG_WIDTH-1:0]   walking_lrd1,
    input  logic [PREG_WIDTH-1:0]   walking_prd1
);

    logic                  w_is_idle;
    logic                  w_is_rollback;
    logic                  w_is_walk;
    logic                  w_eff_wr0;
    logic                  w_eff_wr1;
    logic [1:0]            w_alloc_cnt;
    logic                  w_fire;
    logic [PREG_WIDTH-1:0] w_prd0;
    logic [PREG_WIDTH-1:0] w_prd1;
    rn_slot_t              w_slot0;
    rn_slot_t              w_slot1;

    logic                  r_out_valid;
    rn_slot_t              r_out0;
    rn_slot_t              r_out1;

    logic [LREG_WIDTH-1:0] w_spec_raddr [RAT_RD_PORTS];
    logic [PREG_WIDTH-1:0] w_spec_rdata [RAT_RD_PORTS];
    logic                  w_spec_wen0;
    logic [LREG_WIDTH-1:0] w_spec_waddr0;
    logic [PREG_WIDTH-1:0] w_spec_wdata0;
    logic                  w_spec_wen1;
    logic [LREG_WIDTH-1:0] w_spec_waddr1;
    logic [PREG_WIDTH-1:0] w_spec_wdata1;
    logic [PREG_WIDTH-1:0] w_spec_table_unused [LREG_NUM];

    logic [LREG_WIDTH-1:0] w_arch_raddr [RAT_RD_PORTS];
    logic [PREG_WIDTH-1:0] w_arch_rdata_unused [RAT_RD_PORTS];
    logic                  w_arch_wen0;
    logic                  w_arch_wen1;
    logic [PREG_WIDTH-1:0] w_arch_table [LREG_NUM];

    assign w_is_idle     = (rob_state == ROB_STATE_IDLE);
    assign w_is_rollback = (rob_state == ROB_STATE_ROLLBACK);
    assign w_is_walk     = (rob_state == ROB_STATE_WALK);

    assign w_eff_wr0   = instr0_valid && instr0_lrd_valid && (instr0_lrd != '0);
    assign w_eff_wr1   = instr1_valid && instr1_lrd_valid && (instr1_lrd != '0);
    assign w_alloc_cnt = {1'b0, w_eff_wr0} + {1'b0, w_eff_wr1};

    assign in_ready = w_is_idle && (!r_out_valid || out_ready)
                   && (fl2rn_free_count >= FL_CNT_WIDTH'(w_alloc_cnt));
    assign w_fire   = in_valid && in_ready;

    // The freelist pops from port 0 first, so a lone slot-1 destination takes head 0.
    assign rn2fl_instr0_lrd_valid = w_fire && (w_eff_wr0 || w_eff_wr1);
    assign rn2fl_instr1_lrd_valid = w_fire && w_eff_wr0 && w_eff_wr1;

    assign w_prd0 = w_eff_wr0 ? fl2rn_instr0prd : '0;
    assign w_prd1 = !w_eff_wr1 ? '0 : (w_eff_wr0 ? fl2rn_instr1prd : fl2rn_instr0prd);

    always_comb begin
        w_spec_raddr[0] = instr0_lrs1;
        w_spec_raddr[1] = instr0_lrs2;
        w_spec_raddr[2] = instr1_lrs1;
        w_spec_raddr[3] = instr1_lrs2;
        w_spec_raddr[4] = instr0_lrd;
        w_spec_raddr[5] = instr1_lrd;
        for (int k = 0; k < RAT_RD_PORTS; k++)
            w_arch_raddr[k] = '0;
    end

    always_comb begin
        w_slot0 = '0;
        w_slot1 = '0;
        if (instr0_valid) begin
            w_slot0.valid   = 1'b1;
            w_slot0.prs1    = src_sel(instr0_lrs1, w_spec_rdata[0], 1'b0, '0, '0);
            w_slot0.prs2    = src_sel(instr0_lrs2, w_spec_rdata[1], 1'b0, '0, '0);
            w_slot0.prd     = w_prd0;
            w_slot0.old_prd = w_eff_wr0 ? w_spec_rdata[4] : '0;
        end
        if (instr1_valid) begin
            w_slot1.valid = 1'b1;
            w_slot1.prs1  = src_sel(instr1_lrs1, w_spec_rdata[2], w_eff_wr0, instr0_lrd, w_prd0);
            w_slot1.prs2  = src_sel(instr1_lrs2, w_spec_rdata[3], w_eff_wr0, instr0_lrd, w_prd0);
            w_slot1.prd   = w_prd1;
            if (w_eff_wr1)
                w_slot1.old_prd = (w_eff_wr0 && (instr1_lrd == instr0_lrd)) ? w_prd0
                                                                            : w_spec_rdata[5];
        end
    end

    // Rename writes in IDLE, walk replays in WALK; ROLLBACK uses the bulk load instead.
    always_comb begin
        w_spec_wen0   = 1'b0;
        w_spec_waddr0 = instr0_lrd;
        w_spec_wdata0 = w_prd0;
        w_spec_wen1   = 1'b0;
        w_spec_waddr1 = instr1_lrd;
        w_spec_wdata1 = w_prd1;
        if (w_is_walk) begin
            w_spec_wen0   = walking_valid0 && (walking_lrd0 != '0);
            w_spec_waddr0 = walking_lrd0;
            w_spec_wdata0 = walking_prd0;
            w_spec_wen1   = walking_valid1 && (walking_lrd1 != '0);
            w_spec_waddr1 = walking_lrd1;
            w_spec_wdata1 = walking_prd1;
        end else begin
            w_spec_wen0 = w_fire && w_eff_wr0;
            w_spec_wen1 = w_fire && w_eff_wr1;
        end
    end

    assign w_arch_wen0 = commit0_valid && commit0_need_to_wb && (commit0_lrd != '0);
    assign w_arch_wen1 = commit1_valid && commit1_need_to_wb && (commit1_lrd != '0);

    rat_array u_spec_rat (
        .clock       (clock),
        .reset       (reset),
        .i_raddr     (w_spec_raddr),
        .o_rdata     (w_spec_rdata),
        .i_wen0      (w_spec_wen0),
        .i_waddr0    (w_spec_waddr0),
        .i_wdata0    (w_spec_wdata0),
        .i_wen1      (w_spec_wen1),
        .i_waddr1    (w_spec_waddr1),
        .i_wdata1    (w_spec_wdata1),
        .i_bulk_load (w_is_rollback),
        .i_bulk_data (w_arch_table),
        .o_table     (w_spec_table_unused)
    );

    // Bulk load is never asserted here, so feeding back its own table is harmless.
    rat_array u_arch_rat (
        .clock       (clock),
        .reset       (reset),
        .i_raddr     (w_arch_raddr),
        .o_rdata     (w_arch_rdata_unused),
        .i_wen0      (w_arch_wen0),
        .i_waddr0    (commit0_lrd),
        .i_wdata0    (commit0_prd),
        .i_wen1      (w_arch_wen1),
        .i_waddr1    (commit1_lrd),
        .i_wdata1    (commit1_prd),
        .i_bulk_load (1'b0),
        .i_bulk_data (w_arch_table),
        .o_table     (w_arch_table)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out0      <= '0;
            r_out1      <= '0;
        end else if (w_is_rollback) begin
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out0      <= w_slot0;
            r_out1      <= w_slot1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid          = r_out_valid;
    assign out_instr0_valid   = r_out0.valid;
    assign out_instr0_prs1    = r_out0.prs1;
    assign out_instr0_prs2    = r_out0.prs2;
    assign out_instr0_prd     = r_out0.prd;
    assign out_instr0_old_prd = r_out0.old_prd;
    assign out_instr1_valid   = r_out1.valid;
    assign out_instr1_prs1    = r_out1.prs1;
    assign out_instr1_prs2    = r_out1.prs2;
    assign out_instr1_prd     = r_out1.prd;
    assign out_instr1_old_prd = r_out1.old_prd;

endmodule

// File: tb/tb_rename_table.sv
// Directed bench for rename_table: stimulus pushes hand-computed renamed bundles into a
// queue, a negedge monitor pops and compares whenever dispatch accepts an output.
module tb_rename_table;
    import rename_table_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid, in_ready;
    logic       instr0_valid, instr0_lrd_valid, instr1_valid, instr1_lrd_valid;
    logic [4:0] instr0_lrs1, instr0_lrs2, instr0_lrd, instr1_lrs1, instr1_lrs2, instr1_lrd;
    logic       rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid;
    logic [5:0] fl2rn_instr0prd, fl2rn_instr1prd, fl2rn_free_count;
    logic       out_valid, out_ready, out_instr0_valid, out_instr1_valid;
    logic [5:0] out_instr0_prs1, out_instr0_prs2, out_instr0_prd, out_instr0_old_prd;
    logic [5:0] out_instr1_prs1, out_instr1_prs2, out_instr1_prd, out_instr1_old_prd;
    logic       commit0_valid, commit0_need_to_wb, commit1_valid, commit1_need_to_wb;
    logic [4:0] commit0_lrd, commit1_lrd;
    logic [5:0] commit0_prd, commit1_prd;
    logic [1:0] rob_state;
    logic       walking_valid0, walking_valid1;
    logic [4:0] walking_lrd0, walking_lrd1;
    logic [5:0] walking_prd0, walking_prd1;

    typedef struct {
        logic       v0;
        logic [5:0] a0, b0, d0, o0;
        logic       v1;
        logic [5:0] a1, b1, d1, o1;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    rename_table dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr0_valid(instr0_valid), .instr0_lrs1(instr0_lrs1), .instr0_lrs2(instr0_lrs2),
        .instr0_lrd(instr0_lrd), .instr0_lrd_valid(instr0_lrd_valid),
        .instr1_valid(instr1_valid), .instr1_lrs1(instr1_lrs1), .instr1_lrs2(instr1_lrs2),
        .instr1_lrd(instr1_lrd), .instr1_lrd_valid(instr1_lrd_valid),
        .rn2fl_instr0_lrd_valid(rn2fl_instr0_lrd_valid),
        .rn2fl_instr1_lrd_valid(rn2fl_instr1_lrd_valid),
        .fl2rn_instr0prd(fl2rn_instr0prd), .fl2rn_instr1prd(fl2rn_instr1prd),
        .fl2rn_free_count(fl2rn_free_count),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr0_valid(out_instr0_valid), .out_instr0_prs1(out_instr0_prs1),
        .out_instr0_prs2(out_instr0_prs2), .out_instr0_prd(out_instr0_prd),
        .out_instr0_old_prd(out_instr0_old_prd),
        .out_instr1_valid(out_instr1_valid), .out_instr1_prs1(out_instr1_prs1),
        .out_instr1_prs2(out_instr1_prs2), .out_instr1_prd(out_instr1_prd),
        .out_instr1_old_prd(out_instr1_old_prd),
        .commit0_valid(commit0_valid), .commit0_need_to_wb(commit0_need_to_wb),
        .commit0_lrd(commit0_lrd), .commit0_prd(commit0_prd),
        .commit1_valid(commit1_valid), .commit1_need_to_wb(commit1_need_to_wb),
        .commit1_lrd(commit1_lrd), .commit1_prd(commit1_prd),
        .rob_state(rob_state),
        .walking_valid0(walking_valid0), .walking_lrd0(walking_lrd0), .walking_prd0(walking_prd0),
        .walking_valid1(walking_valid1), .walking_lrd1(walking_lrd1), .walking_prd1(walking_prd1)
    );

    // The ROB never commits outside IDLE.
    always @(posedge clock)
        if (!reset && rob_state != 2'd0)
            assert (!commit0_valid && !commit1_valid);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic v0, input int a0, input int b0, input int d0,
                                input int o0, input logic v1, input int a1, input int b1,
                                input int d1, input int o1);
        exp_t e;
        e.v0 = v0; e.a0 = 6'(a0); e.b0 = 6'(b0); e.d0 = 6'(d0); e.o0 = 6'(o0);
        e.v1 = v1; e.a1 = 6'(a1); e.b1 = 6'(b1); e.d1 = 6'(d1); e.o1 = 6'(o1);
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_out: got out_valid=1 expected no pending bundle");
            end else begin
                e = q.pop_front();
                chk("s0_valid", out_instr0_valid, e.v0);
                chk("s0_prd", out_instr0_prd, e.d0);
                chk("s0_old_prd", out_instr0_old_prd, e.o0);
                if (e.v0) begin
                    chk("s0_prs1", out_instr0_prs1, e.a0);
                    chk("s0_prs2", out_instr0_prs2, e.b0);
                end
                chk("s1_valid", out_instr1_valid, e.v1);
                chk("s1_prd", out_instr1_prd, e.d1);
                chk("s1_old_prd", out_instr1_old_prd, e.o1);
                if (e.v1) begin
                    chk("s1_prs1", out_instr1_prs1, e.a1);
                    chk("s1_prs2", out_instr1_prs2, e.b1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bundle(input logic v0, input int s10, input int s20, input int d0,
                          input logic dv0, input logic v1, input int s11, input int s21,
                          input int d1, input logic dv1, input int h0, input int h1,
                          input int cnt);
        in_valid = 1'b1;
        instr0_valid = v0; instr0_lrs1 = 5'(s10); instr0_lrs2 = 5'(s20);
        instr0_lrd = 5'(d0); instr0_lrd_valid = dv0;
        instr1_valid = v1; instr1_lrs1 = 5'(s11); instr1_lrs2 = 5'(s21);
        instr1_lrd = 5'(d1); instr1_lrd_valid = dv1;
        fl2rn_instr0prd = 6'(h0); fl2rn_instr1prd = 6'(h1); fl2rn_free_count = 6'(cnt);
    endtask

    task automatic idle();
        in_valid = 1'b0; instr0_valid = 1'b0; instr1_valid = 1'b0;
        instr0_lrd_valid = 1'b0; instr1_lrd_valid = 1'b0;
    endtask

    task automatic step(input logic rdy, input logic r0, input logic r1, input exp_t e,
                        input string tag);
        @(negedge clock);
        chk({tag, "_in_ready"}, in_ready, rdy);
        chk({tag, "_fl_req0"}, rn2fl_instr0_lrd_valid, r0);
        chk({tag, "_fl_req1"}, rn2fl_instr1_lrd_valid, r1);
        if (rdy)
            q.push_back(e);
        tick();
    endtask

    initial begin
        exp_t nil;
        nil = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; out_ready = 1'b1; rob_state = 2'd0;
        idle();
        bundle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        commit0_valid = 0; commit0_need_to_wb = 0; commit0_lrd = 0; commit0_prd = 0;
        commit1_valid = 0; commit1_need_to_wb = 0; commit1_lrd = 0; commit1_prd = 0;
        walking_valid0 = 0; walking_lrd0 = 0; walking_prd0 = 0;
        walking_valid1 = 0; walking_lrd1 = 0; walking_prd1 = 0;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s0_prd", out_instr0_prd, 0);
        chk("rst_s1_old_prd", out_instr1_old_prd, 0);
        reset = 1'b0;

        // x1<-x2,x3 ; x4<-x1,x1
        bundle(1, 2, 3, 1, 1, 1, 1, 1, 4, 1, 32, 33, 20);
        step(1, 1, 1, mk(1, 2, 3, 32, 1, 1, 32, 32, 33, 4), "t1");
        // WAW on x5, slot 1 also reads x5 and x4
        bundle(1, 6, 0, 5, 1, 1, 5, 4, 5, 1, 40, 41, 20);
        step(1, 1, 1, mk(1, 6, 0, 40, 5, 1, 40, 33, 41, 40), "t2");
        // only slot 1 allocates: compacted onto freelist port 0
        bundle(1, 5, 1, 9, 0, 1, 1, 2, 7, 1, 44, 45, 20);
        step(1, 1, 0, mk(1, 41, 32, 0, 0, 1, 32, 2, 44, 7), "t3");
        // not enough free entries, then just enough
        bundle(1, 0, 0, 8, 1, 1, 8, 0, 9, 1, 46, 47, 1);
        step(0, 0, 0, nil, "t4a");
        bundle(1, 0, 0, 8, 1, 1, 8, 0, 9, 1, 46, 47, 2);
        step(1, 1, 1, mk(1, 0, 0, 46, 8, 1, 46, 0, 47, 9), "t4b");
        // slot 0 targets x0: no allocation for it
        bundle(1, 7, 8, 0, 1, 1, 0, 9, 10, 1, 48, 49, 1);
        step(1, 1, 0, mk(1, 44, 46, 0, 0, 1, 0, 47, 48, 10), "t5");

        // dispatch stall for three cycles
        out_ready = 1'b0;
        bundle(1, 1, 10, 11, 1, 0, 0, 0, 0, 0, 50, 51, 20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_fl_req0", rn2fl_instr0_lrd_valid, 0);
            chk("stall_s1_prd", out_instr1_prd, 48);
            chk("stall_s1_old_prd", out_instr1_old_prd, 10);
            tick();
        end
        out_ready = 1'b1;
        step(1, 1, 0, mk(1, 32, 48, 50, 11, 0, 0, 0, 0, 0), "t6");

        // commits: x1->32; x3 without writeback ignored; then x2 twice, port 1 wins
        idle();
        commit0_valid = 1; commit0_need_to_wb = 1; commit0_lrd = 1; commit0_prd = 32;
        commit1_valid = 1; commit1_need_to_wb = 0; commit1_lrd = 3; commit1_prd = 9;
        tick();
        commit0_lrd = 2; commit0_prd = 55;
        commit1_need_to_wb = 1; commit1_lrd = 2; commit1_prd = 56;
        tick();
        commit0_valid = 0; commit1_valid = 0;

        bundle(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 52, 53, 20);
        step(1, 1, 0, mk(1, 2, 0, 52, 32, 0, 0, 0, 0, 0), "t7");

        // rollback with a pending, unaccepted output
        out_ready = 1'b0;
        rob_state = 2'd1;
        bundle(1, 3, 4, 5, 1, 1, 6, 7, 8, 1, 1, 2, 20);
        @(negedge clock);
        chk("rb_in_ready", in_ready, 0);
        chk("rb_fl_req0", rn2fl_instr0_lrd_valid, 0);
        chk("rb_pending_valid", out_valid, 1);
        chk("rb_pending_prd", out_instr0_prd, 52);
        tick();
        chk("rb_out_valid", out_valid, 0);
        void'(q.pop_back());
        rob_state = 2'd0;
        out_ready = 1'b1;

        // x1 and x2 from the architectural RAT; x11/x5 back to identity
        bundle(1, 1, 2, 0, 0, 1, 11, 5, 0, 0, 0, 0, 20);
        step(1, 0, 0, mk(1, 32, 56, 0, 0, 1, 11, 5, 0, 0), "t8");

        // walk: (x1,60),(x12,61) then (x13,30),(x13,31)
        idle();
        rob_state = 2'd2;
        bundle(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 2, 3, 20);
        walking_valid0 = 1; walking_lrd0 = 1; walking_prd0 = 60;
        walking_valid1 = 1; walking_lrd1 = 12; walking_prd1 = 61;
        @(negedge clock);
        chk("walk_in_ready", in_ready, 0);
        tick();
        walking_lrd0 = 13; walking_prd0 = 30;
        walking_lrd1 = 13; walking_prd1 = 31;
        tick();
        walking_valid0 = 0; walking_valid1 = 0;
        rob_state = 2'd0;

        bundle(1, 1, 12, 0, 0, 1, 1, 13, 13, 1, 20, 21, 20);
        step(1, 1, 0, mk(1, 60, 61, 0, 0, 1, 60, 31, 20, 31), "t9");

        // reset during a stall and a walk
        idle();
        out_ready = 1'b0;
        reset = 1'b1;
        rob_state = 2'd2;
        walking_valid0 = 1; walking_lrd0 = 1; walking_prd0 = 5;
        tick();
        reset = 1'b0;
        rob_state = 2'd0;
        walking_valid0 = 0;
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_s1_prd", out_instr1_prd, 0);
        chk("rst2_s1_old_prd", out_instr1_old_prd, 0);
        void'(q.pop_back());
        out_ready = 1'b1;

        bundle(1, 1, 13, 0, 0, 1, 12, 20, 0, 0, 0, 0, 20);
        step(1, 0, 0, mk(1, 1, 13, 0, 0, 1, 12, 20, 0, 0), "t10");

        idle();
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_table.md
# rename_table

2-wide register-rename stage for the out-of-order backend: sits between decode and dispatch, directly upstream of the freelist. Holds the speculative RAT (updated at rename) and the architectural RAT (updated at commit), allocates physical destinations from the freelist, resolves intra-bundle dependencies and emits a registered, renamed bundle to dispatch. On a ROB redirect it restores the speculative RAT from the architectural RAT, then replays walked mappings.

## Interface
- LREG_NUM, 32: logical registers; x0 is hard-wired.
- LREG_WIDTH, 5: logical index width.
- PREG_WIDTH, 6: physical index width; matches freelist DATA_WIDTH.
- FL_CNT_WIDTH, 6: width of the freelist free-count input.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode bundle valid.
- in_ready  out  1  rename accepts the bundle.
- instrN_valid  in  1  slot valid, N=0,1; instr1_valid implies instr0_valid.
- instrN_lrs1, instrN_lrs2, instrN_lrd  in  LREG_WIDTH  logical sources and destination.
- instrN_lrd_valid  in  1  slot writes a destination.
- rn2fl_instr0_lrd_valid, rn2fl_instr1_lrd_valid  out  1  freelist allocation requests.
- fl2rn_instr0prd, fl2rn_instr1prd  in  PREG_WIDTH  same-cycle freelist heads.
- fl2rn_free_count  in  FL_CNT_WIDTH  free entries in the freelist.
- out_valid  out  1  renamed bundle valid.
- out_ready  in  1  dispatch accepts.
- out_instrN_valid  out  1  per-slot valid.
- out_instrN_prs1, out_instrN_prs2, out_instrN_prd, out_instrN_old_prd  out  PREG_WIDTH.
- commitN_valid, commitN_need_to_wb  in  1  ROB commit, N=0,1.
- commitN_lrd  in  LREG_WIDTH; commitN_prd  in  PREG_WIDTH.
- rob_state  in  2  ROB_STATE_IDLE / ROB_STATE_ROLLBACK / ROB_STATE_WALK.
- walking_validN  in  1; walking_lrdN  in  LREG_WIDTH; walking_prdN  in  PREG_WIDTH.

## Operation
- Effective destination: eff_wrN = instrN_valid && instrN_lrd_valid && instrN_lrd != 0.
- Allocation compaction: the freelist serves requests in order from port 0. alloc_cnt = eff_wr0 + eff_wr1. If only slot 1 allocates, assert rn2fl_instr0_lrd_valid and give fl2rn_instr0prd to slot 1. Requests are asserted only on fire.
- in_ready = is_idle && (!out_valid || out_ready) && fl2rn_free_count >= alloc_cnt. fire = in_valid && in_ready.
- Source lookup from the speculative RAT; lrs == 0 gives prs 0.
- Intra-bundle bypass:
  - If eff_wr0 and instr1_lrsK == instr0_lrd, then out_instr1_prsK = slot-0 prd.
  - If eff_wr0 and instr1_lrd == instr0_lrd, then out_instr1_old_prd = slot-0 prd.
- old_prd is the speculative mapping of lrd before this bundle. Slots without eff_wr output prd = old_prd = 0.
- Speculative RAT write on fire: slot 0, then slot 1. On WAW, slot 1 wins.
- Architectural RAT write when commitN_valid && commitN_need_to_wb && lrd != 0; same lrd on both ports, commit1 wins. The ROB holds commits at 0 outside IDLE; the bench asserts this.
- States follow rob_state:
  - IDLE: rename enabled.
  - ROLLBACK: speculative RAT ← architectural RAT in one cycle; out_valid cleared; in_ready = 0.
  - WALK: apply walking_validN (lrd, prd) to the speculative RAT, walk1 winning on the same lrd; in_ready = 0.
- Reset: both RATs map lr i → pr i for i = 0..31. This is consistent with the freelist holding 32..63. out_valid = 0 and all out_* = 0.

## Timing
- Lookup, bypass and freelist request are combinational in the fire cycle. The output register loads at the fire edge, so latency is 1 cycle.
- Output holds stable while out_valid && !out_ready.
- The speculative RAT write lands at the fire edge, so a bundle in the next cycle sees the new mappings.
- ROLLBACK takes priority over a pending output: out_valid drops the next cycle regardless of out_ready.
- Reset asserted mid-walk or mid-stall returns to the reset mapping next cycle.

## Structure
- Shared package (rename_pkg or existing defines): ROB_STATE_IDLE=0, ROB_STATE_ROLLBACK=1, ROB_STATE_WALK=2, plus LREG_WIDTH / PREG_WIDTH constants.
- Sub-module rat_array: LREG_NUM×PREG_WIDTH storage with 6 async read ports, 2 prioritized write ports, reset-to-identity and a bulk-load input. Instantiate it twice: speculative RAT with bulk-load from the architectural RAT, architectural RAT with bulk-load tied off.

## Test plan
- Reset, then rename add x1←x2,x3 and x4←x1,x1 in one bundle, free heads 32/33 → prs=2,3, prd=32, old=1; slot1 prs1=prs2=32, prd=33, old=4.
- WAW: both slots write x5, heads 40/41 → slot1 old_prd=40; next bundle reading x5 sees 41.
- Slot 0 without dest, slot 1 writes x7 → only rn2fl_instr0_lrd_valid=1; slot1 prd=fl2rn_instr0prd.
- fl2rn_free_count=1 with two dests → in_ready=0, no freelist request; count=2 → fire.
- out_ready=0 for 3 cycles → output stable, in_ready=0; then accept.
- Commit x1→32, rename x1→50, ROLLBACK, then WALK (x1,60) → a lookup of x1 returns 32 after rollback and 60 after the walk; out_valid cleared in the ROLLBACK cycle.
